factor_search: RTL

//   Inverse of the factorizer: given a required divisibility bitmap (same bit map: bit i <=> divisible by i+2),

---
 rtl/factor_pkg.sv | 21 ++
 rtl/factor_search_if.sv | 24 ++
 rtl/factor_search_mod_counter.sv | 26 ++
 rtl/factor_search.sv | 96 +++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared definitions for the factorizer family. Bit i of a factor bitmap means "divisible by i+2".
package factor_pkg;

  localparam int unsigned MAX_DIVISOR = 15;
  localparam int unsigned FACTOR_W    = MAX_DIVISOR - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESULT = 2'd2
  } state_t;

  function automatic int unsigned divisor_of(input int unsigned idx);
    return idx + 2;
  endfunction

  function automatic int unsigned index_of(input int unsigned divisor);
    return divisor - 2;
  endfunction

endpackage

// File: rtl/factor_search_if.sv
// Request/result bundle for factor_search: master issues searches, slave reports results.
interface factor_search_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FACTOR_W = factor_pkg::FACTOR_W
);
  logic                start;
  logic                abort;
  logic                exact;
  logic [FACTOR_W-1:0] mask;
  logic                busy;
  logic                done;
  logic                found;
  logic [WIDTH-1:0]    number;

  modport master (
    output start, abort, exact, mask,
    input  busy, done, found, number
  );

  modport slave (
    input  start, abort, exact, mask,
    output busy, done, found, number
  );
endinterface

// File: rtl/factor_search_mod_counter.sv
// Residue counter modulo MODULUS: tracks candidate mod MODULUS by increment-with-wrap.
module mod_counter #(
  parameter int unsigned MODULUS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic inc,
  output logic is_zero
);
  localparam int unsigned RW = $clog2(MODULUS);

  logic [RW-1:0] r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r <= '0;
    end else if (load) begin
      r <= RW'(1);
    end else if (inc) begin
      r <= (r == RW'(MODULUS - 1)) ? '0 : r + 1'b1;
    end
  end

  assign is_zero = (r == '0);
endmodule

// File: rtl/factor_search.sv
// Scans candidates 1..2^WIDTH-1 and reports the smallest whose divisibility flags match the mask.
module factor_search #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_DIVISOR = factor_pkg::MAX_DIVISOR
) (
  input  logic            clk,
  input  logic            reset_n,
  factor_search_if.slave  bus
);
  import factor_pkg::*;

  localparam int unsigned FLAGS_W = MAX_DIVISOR - 1;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     candidate;
  logic [FLAGS_W-1:0]   mask_q;
  logic [FLAGS_W-1:0]   flags;
  logic                 exact_q;
  logic                 found_q;
  logic [WIDTH-1:0]     number_q;
  logic                 accept;
  logic                 last;
  logic                 match;
  logic                 step;

  assign accept = bus.start && (state != SEARCH);
  assign last   = (candidate == '1);
  assign match  = exact_q ? (flags == mask_q) : ((flags & mask_q) == mask_q);
  assign step   = (state == SEARCH) && !bus.abort && !match && !last;

  // Residues track the candidate incrementally so no divider is needed.
  for (genvar k = 2; k <= MAX_DIVISOR; k++) begin : g_res
    mod_counter #(.MODULUS(k)) u_mod (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept),
      .inc     (step),
      .is_zero (flags[k-2])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH: begin
        if (bus.abort)          state_nxt = IDLE;
        else if (match || last) state_nxt = RESULT;
      end
      RESULT:  state_nxt = accept ? SEARCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      mask_q    <= '0;
      exact_q   <= 1'b0;
      found_q   <= 1'b0;
      number_q  <= '0;
    end else if (accept) begin
      candidate <= WIDTH'(1);
      mask_q    <= bus.mask;
      exact_q   <= bus.exact;
      found_q   <= 1'b0;
      number_q  <= '0;
    end else if (state == SEARCH) begin
      if (bus.abort) begin
        found_q  <= 1'b0;
        number_q <= '0;
      end else if (match) begin
        found_q  <= 1'b1;
        number_q <= candidate;
      end else if (last) begin
        found_q  <= 1'b0;
        number_q <= '0;
      end else begin
        candidate <= candidate + 1'b1;
      end
    end
  end

  assign bus.busy   = (state == SEARCH);
  assign bus.done   = (state == RESULT);
  assign bus.found  = found_q;
  assign bus.number = number_q;
endmodule
